state_queue_ctrl: RTL and testbench

Circular-FIFO controller that drives the single-port 256 x 17-bit state memory as its initiator. It turns it into the solver's open-list queue: push/pop valid-ready handshakes on the client side, address/write-data/write-enable on the memory side. After reset or flush it sweeps the memory to zero before accepting traffic. It sits between the search FSM and the state memory; it is the only master of that memory's port.

---
 rtl/state_queue_ctrl.sv | 135 +++++++++++++
 tb/tb_state_queue_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/state_queue_ctrl.sv
// Circular-FIFO controller that owns the single-port state memory and presents it as a
// push/pop queue; sweeps the memory to zero after reset or flush before accepting traffic.
module state_queue_ctrl #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned PTR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              last_pop_q, last_pop_d;
  logic              push_can, pop_can, push_grant, pop_grant;

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pop_valid_d = 1'b0;
    pop_data_d  = pop_data_q;
    last_pop_d  = last_pop_q;
    push_ready  = 1'b0;
    pop_ready   = 1'b0;
    busy        = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = ADDR_W'(head_q);
    mem_wdata   = '0;
    push_can    = push_valid && !full;
    pop_can     = pop_req && !empty;
    push_grant  = 1'b0;
    pop_grant   = 1'b0;

    unique case (state_q)
      StClear: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(clr_ptr_q);
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == PTR_W'(DEPTH - 1)) state_d = StRun;
      end
      StRun: begin
        if (!flush) begin
          // On a tie the side that did not fire last time wins.
          push_grant = push_can && (!pop_can || last_pop_q);
          pop_grant  = pop_can && (!push_can || !last_pop_q);
          push_ready = !full && !pop_grant;
          pop_ready  = !empty && !push_grant;
          if (push_grant) begin
            mem_we     = 1'b1;
            mem_addr   = ADDR_W'(tail_q);
            mem_wdata  = push_data;
            tail_d     = tail_q + 1'b1;
            count_d    = count_q + 1'b1;
            last_pop_d = 1'b0;
          end else if (pop_grant) begin
            pop_data_d  = mem_rdata;
            pop_valid_d = 1'b1;
            head_d      = head_q + 1'b1;
            count_d     = count_q - 1'b1;
            last_pop_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (flush) begin
      state_d     = StClear;
      clr_ptr_d   = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      pop_valid_d = 1'b0;
    end

    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      clr_ptr_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      last_pop_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      last_pop_q  <= last_pop_d;
    end
  end

endmodule

// File: tb/tb_state_queue_ctrl.sv
// Scoreboard bench for state_queue_ctrl: expected pop data is queued at each pop fire and
// compared by a monitor whenever pop_valid is seen.
module tb_state_queue_ctrl;

  localparam int unsigned DATA_W = 17;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned PTR_W  = 8;

  logic              clk = 1'b0;
  logic              rst, flush, push_valid, pop_req;
  logic [DATA_W-1:0] push_data;
  logic              push_ready, pop_ready, pop_valid, empty, full, busy, mem_we;
  logic [DATA_W-1:0] pop_data, mem_wdata, mem_rdata;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] mq [$];
  int                checks = 0;
  int                failures = 0;

  state_queue_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_data(pop_data),
    .count(count), .empty(empty), .full(full), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[PTR_W-1:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[PTR_W-1:0]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_push(input logic [DATA_W-1:0] d);
    push_valid = 1'b1;
    push_data  = d;
    #1;
    check("push_ready", 32'(push_ready), 32'd1);
    mq.push_back(d);
    step();
    push_valid = 1'b0;
  endtask

  task automatic do_pop();
    pop_req = 1'b1;
    #1;
    check("pop_ready", 32'(pop_ready), 32'd1);
    if (mq.size() > 0) sb.push_back(mq.pop_front());
    step();
    pop_req = 1'b0;
  endtask

  // Expects to be entered in sweep cycle 0; returns in the first RUN cycle.
  task automatic sweep_check(input string name);
    int bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      #1;
      if (!(busy && mem_we && mem_addr == ADDR_W'(i) && mem_wdata == '0)) bad++;
      step();
    end
    check({name, "_bad_cycles"}, 32'(bad), 32'd0);
    #1;
    check({name, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_req = 1'b0; push_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 17'h15555;

    fork
      forever begin
        @(negedge clk);
        if (!rst && pop_valid) begin
          if (sb.size() == 0) check("pop_valid_spurious", 32'd1, 32'd0);
          else check("pop_data", 32'(pop_data), 32'(sb.pop_front()));
        end
      end
    join_none

    repeat (3) @(negedge clk);
    #1;
    check("rst_push_ready", 32'(push_ready), 32'd0);
    check("rst_pop_ready", 32'(pop_ready), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_pop_data", 32'(pop_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", {29'd0, empty, full, busy}, 32'b101);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep_check("init_sweep");
    push_valid = 1'b1;
    #1;
    check("init_push_ready", 32'(push_ready), 32'd1);
    push_valid = 1'b0;

    // Basic order
    do_push(17'h1ABCD);
    do_push(17'h00001);
    do_push(17'h1FFFF);
    check("basic_count3", 32'(count), 32'd3);
    for (int k = 2; k >= 0; k--) begin
      do_pop();
      check("basic_count_dn", 32'(count), 32'(k));
    end
    check("basic_empty", 32'(empty), 32'd1);

    // Flush with ten entries; pop_data from the pre-flush pop must survive
    for (int i = 0; i < 11; i++) do_push(17'(32'h100 + i));
    do_pop();
    check("flush_count10", 32'(count), 32'd10);
    flush = 1'b1; push_valid = 1'b1; pop_req = 1'b1;
    #1;
    check("flush_readies", {30'd0, push_ready, pop_ready}, 32'd0);
    step();
    flush = 1'b0; push_valid = 1'b0; pop_req = 1'b0;
    mq.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_pop_valid", 32'(pop_valid), 32'd0);
    check("flush_pop_data_kept", 32'(pop_data), 32'h100);
    sweep_check("flush_sweep");

    // Fill to full, pop one, then the held push lands at slot 0
    for (int i = 0; i < int'(DEPTH); i++) do_push(17'(i));
    check("fill_count", 32'(count), 32'(DEPTH));
    check("fill_full", 32'(full), 32'd1);
    push_valid = 1'b1; push_data = 17'h1F00F;
    #1;
    check("full_push_ready", 32'(push_ready), 32'd0);
    do_pop();
    push_valid = 1'b1;
    #1;
    check("wrap_push_ready", 32'(push_ready), 32'd1);
    check("wrap_mem_addr", 32'(mem_addr), 32'd0);
    check("wrap_mem_we", 32'(mem_we), 32'd1);
    mq.push_back(17'h1F00F);
    step();
    push_valid = 1'b0;
    check("wrap_count", 32'(count), 32'(DEPTH));

    // Drain to five entries, then contend for four cycles
    for (int i = 0; i < int'(DEPTH) - 5; i++) do_pop();
    check("arb_count_start", 32'(count), 32'd5);
    for (int k = 0; k < 4; k++) begin
      push_valid = 1'b1; pop_req = 1'b1; push_data = 17'(32'hAA00 + k);
      #1;
      check("arb_grant", {30'd0, push_ready, pop_ready}, (k % 2 == 0) ? 32'b10 : 32'b01);
      if (k % 2 == 0) mq.push_back(push_data);
      else sb.push_back(mq.pop_front());
      step();
    end
    push_valid = 1'b0; pop_req = 1'b0;
    check("arb_count_end", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) do_pop();
    check("drain_empty", 32'(empty), 32'd1);

    // Empty queue: simultaneous pop and push, only the push is taken
    push_valid = 1'b1; pop_req = 1'b1; push_data = 17'h00042;
    #1;
    check("tie_empty_pop_ready", 32'(pop_ready), 32'd0);
    check("tie_empty_push_ready", 32'(push_ready), 32'd1);
    mq.push_back(17'h00042);
    step();
    push_valid = 1'b0;
    do_pop();
    check("tie_pop_valid", 32'(pop_valid), 32'd1);
    step();
    check("tie_pop_valid_drop", 32'(pop_valid), 32'd0);

    step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_count", 32'(count), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
